// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: major opcodes, immediate formats and the
// registered decode bundle used by the output and skid entries.
package decode_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'h03;
    localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
    localparam logic [6:0] OPC_OP_IMM   = 7'h13;
    localparam logic [6:0] OPC_AUIPC    = 7'h17;
    localparam logic [6:0] OPC_STORE    = 7'h23;
    localparam logic [6:0] OPC_OP       = 7'h33;
    localparam logic [6:0] OPC_LUI      = 7'h37;
    localparam logic [6:0] OPC_BRANCH   = 7'h63;
    localparam logic [6:0] OPC_JALR     = 7'h67;
    localparam logic [6:0] OPC_JAL      = 7'h6F;
    localparam logic [6:0] OPC_SYSTEM   = 7'h73;

    typedef enum logic [2:0] {
        IMM_R = 3'd0,
        IMM_I = 3'd1,
        IMM_S = 3'd2,
        IMM_B = 3'd3,
        IMM_U = 3'd4,
        IMM_J = 3'd5
    } imm_type_t;

    // Width-independent fields; imm and pc sit in parallel registers because
    // their widths are parameters of the stage.
    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [6:0] funct7;
        imm_type_t  imm_type;
        logic       rs1_used;
        logic       rs2_used;
        logic       rd_we;
        logic       illegal;
    } decode_bundle_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: picks the RV32I immediate format from the opcode and
// sign-extends the assembled 32-bit immediate to DATA_WIDTH.
module imm_gen
    import decode_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [31:0]           instr,
    output logic [DATA_WIDTH-1:0] imm,
    output logic [2:0]            imm_type
);

    imm_type_t   fmt;
    logic [31:0] imm32;

    always_comb begin
        fmt = IMM_R;
        case (instr[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: fmt = IMM_I;
            OPC_STORE:                                                fmt = IMM_S;
            OPC_BRANCH:                                               fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:                                       fmt = IMM_U;
            OPC_JAL:                                                  fmt = IMM_J;
            default:                                                  fmt = IMM_R;
        endcase
    end

    always_comb begin
        imm32 = '0;
        case (fmt)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Signed size cast replicates bit 31 upward when DATA_WIDTH is 64.
    assign imm      = DATA_WIDTH'($signed(imm32));
    assign imm_type = fmt;

endmodule

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: decodes on the input side and registers the
// bundle behind a valid/ready handshake with one skid entry.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [6:0]            opcode,
    output logic [4:0]            rd,
    output logic [4:0]            rs1,
    output logic [4:0]            rs2,
    output logic [2:0]            funct3,
    output logic [6:0]            funct7,
    output logic [DATA_WIDTH-1:0] imm,
    output logic [2:0]            imm_type,
    output logic                  rs1_used,
    output logic                  rs2_used,
    output logic                  rd_we,
    output logic                  illegal
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [DATA_WIDTH-1:0] gen_imm;
    logic [2:0]            gen_imm_type;

    imm_gen #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_imm_gen (
        .instr   (in_instr),
        .imm     (gen_imm),
        .imm_type(gen_imm_type)
    );

    logic                  dec_legal;
    logic                  dec_reads_rs1;
    logic                  dec_reads_rs2;
    logic                  dec_writes_rd;
    decode_bundle_t        dec;
    logic [DATA_WIDTH-1:0] dec_imm;

    always_comb begin
        dec_legal     = 1'b1;
        dec_reads_rs1 = 1'b0;
        dec_reads_rs2 = 1'b0;
        dec_writes_rd = 1'b0;
        case (in_instr[6:0])
            OPC_OP: begin
                dec_reads_rs1 = 1'b1;
                dec_reads_rs2 = 1'b1;
                dec_writes_rd = 1'b1;
            end
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
                dec_reads_rs1 = 1'b1;
                dec_writes_rd = 1'b1;
            end
            OPC_SYSTEM:         dec_writes_rd = 1'b1;
            OPC_MISC_MEM:       dec_legal     = 1'b1;
            OPC_STORE, OPC_BRANCH: begin
                dec_reads_rs1 = 1'b1;
                dec_reads_rs2 = 1'b1;
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL: dec_writes_rd = 1'b1;
            default:            dec_legal     = 1'b0;
        endcase
        if (in_instr[1:0] != 2'b11) begin
            dec_legal = 1'b0;
        end
    end

    // Illegal instructions still flow as valid bundles, but with every
    // side effect stripped so execute only has to raise the trap.
    always_comb begin
        dec          = '0;
        dec.opcode   = in_instr[6:0];
        dec.rs1      = in_instr[19:15];
        dec.rs2      = in_instr[24:20];
        dec.funct3   = in_instr[14:12];
        dec.funct7   = in_instr[31:25];
        dec.illegal  = ~dec_legal;
        dec.rs1_used = dec_legal & dec_reads_rs1;
        dec.rs2_used = dec_legal & dec_reads_rs2;
        dec.rd_we    = dec_legal & dec_writes_rd & (in_instr[11:7] != 5'd0);
        dec.rd       = dec.rd_we ? in_instr[11:7] : 5'd0;
        dec.imm_type = dec_legal ? imm_type_t'(gen_imm_type) : IMM_R;
        dec_imm      = dec_legal ? gen_imm : '0;
    end

    logic [1:0]            state_q, state_d;
    logic                  in_ready_q;
    logic                  out_valid_q;
    decode_bundle_t        out_q, skid_q;
    logic [DATA_WIDTH-1:0] out_imm_q, skid_imm_q;
    logic [ADDR_WIDTH-1:0] out_pc_q, skid_pc_q;

    logic in_xfer;
    logic out_xfer;
    logic load_out_dec;
    logic load_out_skid;
    logic load_skid;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    // Flush wins over everything; a same-cycle out-transfer is still taken
    // by execute, a same-cycle in-transfer is simply never stored.
    always_comb begin
        state_d       = state_q;
        load_out_dec  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d      = ST_ONE;
                        load_out_dec = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        load_out_dec = 1'b1;
                    end else if (in_xfer) begin
                        state_d   = ST_TWO;
                        load_skid = 1'b1;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_xfer) begin
                        state_d       = ST_ONE;
                        load_out_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_imm_q   <= '0;
            out_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != ST_TWO);
            out_valid_q <= (state_d != ST_EMPTY);
            if (load_out_dec) begin
                out_q     <= dec;
                out_imm_q <= dec_imm;
                out_pc_q  <= in_pc;
            end else if (load_out_skid) begin
                out_q     <= skid_q;
                out_imm_q <= skid_imm_q;
                out_pc_q  <= skid_pc_q;
            end
        end
    end

    // Skid contents are only meaningful in ST_TWO, so they need no reset.
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_q     <= dec;
            skid_imm_q <= dec_imm;
            skid_pc_q  <= in_pc;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign opcode    = out_q.opcode;
    assign rd        = out_q.rd;
    assign rs1       = out_q.rs1;
    assign rs2       = out_q.rs2;
    assign funct3    = out_q.funct3;
    assign funct7    = out_q.funct7;
    assign imm       = out_imm_q;
    assign imm_type  = out_q.imm_type;
    assign rs1_used  = out_q.rs1_used;
    assign rs2_used  = out_q.rs2_used;
    assign rd_we     = out_q.rd_we;
    assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a queue-based reference model plus
// directed literal checks, with a 64-bit instance sharing the same stimulus.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        arst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, rs1_used, rs2_used, rd_we, illegal;
    logic [31:0] out_pc, imm;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3, imm_type;

    logic        in_ready_w, out_valid_w, rs1_used_w, rs2_used_w, rd_we_w, illegal_w;
    logic [31:0] out_pc_w;
    logic [63:0] imm_w;
    logic [6:0]  opcode_w, funct7_w;
    logic [4:0]  rd_w, rs1_w, rs2_w;
    logic [2:0]  funct3_w, imm_type_w;

    always #5 clk = ~clk;

    decode_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .arst(arst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
        .imm(imm), .imm_type(imm_type), .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rd_we(rd_we), .illegal(illegal)
    );

    decode_stage #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut64 (
        .clk(clk), .arst(arst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_w), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_pc(out_pc_w),
        .opcode(opcode_w), .rd(rd_w), .rs1(rs1_w), .rs2(rs2_w), .funct3(funct3_w),
        .funct7(funct7_w), .imm(imm_w), .imm_type(imm_type_w), .rs1_used(rs1_used_w),
        .rs2_used(rs2_used_w), .rd_we(rd_we_w), .illegal(illegal_w)
    );

    int n_checks = 0;
    int n_pass = 0;
    bit done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } item_t;

    typedef struct {
        logic [6:0]  opc;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
        int          ity;
        bit          r1u, r2u, we, ill;
    } exp_t;

    item_t q[$];

    function automatic longint fld(input logic [31:0] x, input int hi, input int lo);
        return (longint'({32'b0, x}) >> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
    endfunction

    function automatic longint sext(input longint v, input int bits);
        return (v << (64 - bits)) >>> (64 - bits);
    endfunction

    function automatic exp_t model_decode(input logic [31:0] x);
        exp_t   e;
        longint v;
        e.opc = x[6:0];
        e.rs1 = x[19:15];
        e.rs2 = x[24:20];
        e.f3  = x[14:12];
        e.f7  = x[31:25];
        e.ity = 0;
        e.r1u = 0; e.r2u = 0; e.we = 0; e.ill = 0;
        case (x[6:0])
            7'h33:               begin e.ity = 0; e.r1u = 1; e.r2u = 1; e.we = 1; end
            7'h03, 7'h13, 7'h67: begin e.ity = 1; e.r1u = 1; e.we = 1; end
            7'h73:               begin e.ity = 1; e.we = 1; end
            7'h0F:               e.ity = 1;
            7'h23:               begin e.ity = 2; e.r1u = 1; e.r2u = 1; end
            7'h63:               begin e.ity = 3; e.r1u = 1; e.r2u = 1; end
            7'h37, 7'h17:        begin e.ity = 4; e.we = 1; end
            7'h6F:               begin e.ity = 5; e.we = 1; end
            default:             e.ill = 1;
        endcase
        case (e.ity)
            1: v = sext(fld(x, 31, 20), 12);
            2: v = sext(fld(x, 31, 25) * 32 + fld(x, 11, 7), 12);
            3: v = sext(fld(x, 31, 31) * 4096 + fld(x, 7, 7) * 2048
                        + fld(x, 30, 25) * 32 + fld(x, 11, 8) * 2, 13);
            4: v = sext(fld(x, 31, 12) * 4096, 32);
            5: v = sext(fld(x, 31, 31) * (1 << 20) + fld(x, 19, 12) * 4096
                        + fld(x, 20, 20) * 2048 + fld(x, 30, 21) * 2, 21);
            default: v = 0;
        endcase
        e.imm = v;
        if (x[11:7] == 5'd0) e.we = 0;
        e.rd = e.we ? x[11:7] : 5'd0;
        return e;
    endfunction

    // Queue update at every edge: pop what execute took, push what fetch gave.
    initial begin
        bit    ix, ox;
        item_t it;
        forever begin
            @(posedge clk or posedge arst);
            if (arst) begin
                q.delete();
            end else begin
                ix = in_valid && (q.size() < 2);
                ox = out_ready && (q.size() > 0);
                if (flush) begin
                    q.delete();
                end else begin
                    if (ox) void'(q.pop_front());
                    if (ix) begin
                        it.instr = in_instr;
                        it.pc    = in_pc;
                        q.push_back(it);
                    end
                end
            end
        end
    end

    // Compare every cycle on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) break;
            if (arst) begin
                chk("rst_out_valid", out_valid, 0);
                chk("rst_in_ready", in_ready, 1);
            end else begin
                chk("in_ready", in_ready, q.size() < 2);
                chk("out_valid", out_valid, q.size() > 0);
                chk("out_valid_64", out_valid_w, q.size() > 0);
                if (q.size() > 0) begin
                    e = model_decode(q[0].instr);
                    chk("out_pc", out_pc, q[0].pc);
                    chk("imm32", imm, e.imm[31:0]);
                    chk("imm64", imm_w, e.imm);
                    chk("fields",
                        {opcode, rd, rs1, rs2, funct3, funct7, imm_type,
                         rs1_used, rs2_used, rd_we, illegal},
                        {e.opc, e.rd, e.rs1, e.rs2, e.f3, e.f7, 3'(e.ity),
                         e.r1u, e.r2u, e.we, e.ill});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] x, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = x;
        in_pc    = pc;
    endtask

    logic [31:0] fmt_instr[4] = '{32'h00112223, 32'hFE000EE3, 32'h12345037, 32'h001000EF};
    logic [31:0] fmt_imm[4]   = '{32'h00000004, 32'hFFFFFFFC, 32'h12345000, 32'h00000800};
    logic [2:0]  fmt_type[4]  = '{3'd2, 3'd3, 3'd4, 3'd5};
    logic [31:0] ill_instr[2] = '{32'h00000000, 32'h0000007F};
    logic [6:0]  opc_tab[11]  = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                                  7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};

    initial begin
        exp_t        e;
        logic [31:0] r;
        #1 arst = 1'b1;
        #2;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_pc", out_pc, 0);
        chk("reset_imm", imm, 0);
        chk("reset_rd_we", rd_we, 0);
        step();
        step();
        arst = 1'b0;

        // Pin the model itself against hand-computed immediates.
        for (int i = 0; i < 4; i++) begin
            e = model_decode(fmt_instr[i]);
            chk("model_imm", e.imm[31:0], fmt_imm[i]);
        end
        e = model_decode(fmt_instr[1]);
        chk("model_beq_imm64", e.imm, 64'hFFFFFFFFFFFFFFFC);

        // Basic decode.
        out_ready = 1'b1;
        drive(32'hFFF10093, 32'h100);
        step();
        in_valid = 1'b0;
        chk("basic_out_valid", out_valid, 1);
        chk("basic_rd", rd, 1);
        chk("basic_rs1", rs1, 2);
        chk("basic_imm", imm, 32'hFFFFFFFF);
        chk("basic_imm_type", imm_type, 1);
        chk("basic_rd_we", rd_we, 1);
        chk("basic_rs2_used", rs2_used, 0);
        chk("basic_out_pc", out_pc, 32'h100);
        step();

        // Immediate formats back-to-back.
        for (int i = 0; i < 4; i++) begin
            drive(fmt_instr[i], 32'h300 + 32'(4 * i));
            step();
            chk("fmt_imm", imm, fmt_imm[i]);
            chk("fmt_imm_type", imm_type, fmt_type[i]);
        end
        in_valid = 1'b0;
        step();
        drive(fmt_instr[1], 32'h340);
        step();
        in_valid = 1'b0;
        chk("beq_imm_64", imm_w, 64'hFFFFFFFFFFFFFFFC);
        step();

        // Backpressure: two accepted, third held off.
        out_ready = 1'b0;
        drive(32'h00500113, 32'h200);
        step();
        drive(32'h00A00193, 32'h204);
        step();
        chk("bp_in_ready", in_ready, 0);
        drive(32'h00F00213, 32'h208);
        step();
        chk("bp_in_ready_held", in_ready, 0);
        chk("bp_out_pc_stable", out_pc, 32'h200);
        chk("bp_imm_stable", imm, 32'd5);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_drain_pc", out_pc, 32'h204);
        chk("bp_drain_imm", imm, 32'd10);
        step();
        chk("bp_drained", out_valid, 0);

        // Flush from full, with a same-cycle input that must be dropped.
        out_ready = 1'b0;
        drive(32'h00500113, 32'h600);
        step();
        drive(32'h00A00193, 32'h604);
        step();
        drive(32'h00100293, 32'h608);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        step();
        chk("flush_dropped", out_valid, 0);

        // Illegal instructions.
        for (int i = 0; i < 2; i++) begin
            drive(ill_instr[i], 32'h700 + 32'(4 * i));
            step();
            in_valid = 1'b0;
            chk("ill_flag", illegal, 1);
            chk("ill_imm", imm, 0);
            chk("ill_rd_we", rd_we, 0);
            chk("ill_rs1_used", rs1_used, 0);
            chk("ill_rs2_used", rs2_used, 0);
            chk("ill_out_valid", out_valid, 1);
        end
        step();

        // Asynchronous reset while full.
        out_ready = 1'b0;
        drive(32'h00500113, 32'h800);
        step();
        drive(32'h00A00193, 32'h804);
        step();
        in_valid = 1'b0;
        #2 arst = 1'b1;
        #1;
        chk("arst_out_valid_async", out_valid, 0);
        chk("arst_in_ready_async", in_ready, 1);
        step();
        arst      = 1'b0;
        out_ready = 1'b1;
        drive(32'hFFF10093, 32'h500);
        step();
        in_valid = 1'b0;
        chk("post_rst_rd", rd, 1);
        chk("post_rst_imm", imm, 32'hFFFFFFFF);
        chk("post_rst_pc", out_pc, 32'h500);
        step();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            r         = $urandom;
            if ($urandom_range(0, 9) == 0) in_instr = r;
            else in_instr = {r[31:7], opc_tab[$urandom_range(0, 10)]};
            in_pc = $urandom & 32'hFFFFFFFC;
            step();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10 && out_valid; k++) step();
        chk("final_drain", out_valid, 0);

        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipelined successor to the combinational decode slice; sits between fetch and execute.
- Decodes every RV32I format: full immediate generation (I/S/B/U/J), register-use flags and illegal-opcode detection.
- Registers results behind a valid/ready handshake with a skid entry, so fetch and execute stalls decouple without combinational ready paths.
- Carries the PC alongside the decoded fields.

Parameters:
- DATA_WIDTH, 32, datapath width; imm sign-extended to this width; legal values 32 or 64.
- ADDR_WIDTH, 32, PC width.

Ports:
- clk  input  1  clock, rising edge.
- arst  input  1  asynchronous active-high reset.
- flush  input  1  kill all held entries (branch/trap redirect).
- in_valid  input  1  fetch presents instruction.
- in_ready  output  1  stage accepts; registered, equals skid-empty.
- in_instr  input  32  raw instruction.
- in_pc  input  ADDR_WIDTH  instruction address.
- out_valid  output  1  decoded bundle valid.
- out_ready  input  1  execute accepts.
- out_pc  output  ADDR_WIDTH  PC of bundle.
- opcode  output  7  instr[6:0].
- rd  output  5  instr[11:7]; forced 0 when rd_we=0.
- rs1  output  5  instr[19:15].
- rs2  output  5  instr[24:20].
- funct3  output  3  instr[14:12].
- funct7  output  7  instr[31:25].
- imm  output  DATA_WIDTH  sign-extended immediate.
- imm_type  output  3  imm_type_t format code.
- rs1_used  output  1  instruction reads rs1.
- rs2_used  output  1  instruction reads rs2.
- rd_we  output  1  instruction writes rd, rd≠0.
- illegal  output  1  unsupported opcode, or instr[1:0]≠2'b11.

Behaviour:
- Reset (arst high, async): all outputs 0, in_ready=1, state EMPTY. Skid contents don't care.
- Transfer rules:
  - in-transfer = in_valid & in_ready.
  - out-transfer = out_valid & out_ready.
  - Decode happens on the input side; registered bundle appears on the outputs 1 cycle after acceptance.
- States:
  - EMPTY: out_valid=0.
  - ONE: output register valid, skid empty.
  - TWO: output and skid both valid, in_ready=0.
- Transitions:
  - EMPTY: in-transfer → ONE.
  - ONE: in-transfer & out-transfer → ONE with new bundle.
  - ONE: in-transfer only → TWO, new bundle into skid.
  - ONE: out-transfer only → EMPTY.
  - TWO: out-transfer → ONE, skid moves to output.
  - TWO: no in-transfer possible.
- Output bundle holds stable while out_valid & !out_ready.
- Flush:
  - Highest priority; next state EMPTY, out_valid=0, in_ready=1.
  - An in-transfer in the same cycle is dropped.
  - An out-transfer in the same cycle is still counted as consumed by execute.
- Immediate by opcode (s = instr[31], extended to DATA_WIDTH):
  - I (LOAD, OP-IMM, JALR, SYSTEM, MISC-MEM): {s.., instr[31:20]}.
  - S (STORE): {s.., instr[31:25], instr[11:7]}.
  - B (BRANCH): {s.., instr[7], instr[30:25], instr[11:8], 0}.
  - U (LUI, AUIPC): {s.. above bit 31, instr[31:12], 12'b0}.
  - J (JAL): {s.., instr[19:12], instr[20], instr[30:21], 0}.
  - R (OP) and illegal: imm = 0.
- Usage flags:
  - rs1_used: R, I except SYSTEM/MISC-MEM, S, B.
  - rs2_used: R, S, B.
  - rd_we: R, I except MISC-MEM, U, J, and rd≠0.
- Illegal instructions:
  - rs1_used, rs2_used, rd_we all forced 0.
  - Still travel as valid bundles so execute can trap precisely with out_pc.

Decomposition:
- Package decode_pkg: opcode localparams (OPC_LOAD 7'h03, OPC_MISC_MEM 7'h0F, OPC_OP_IMM 7'h13, OPC_AUIPC 7'h17, OPC_STORE 7'h23, OPC_OP 7'h33, OPC_LUI 7'h37, OPC_BRANCH 7'h63, OPC_JALR 7'h67, OPC_JAL 7'h6F, OPC_SYSTEM 7'h73).
- decode_pkg also holds enum imm_type_t {IMM_R=0, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} and packed struct decode_bundle_t, used for both the output and skid registers.
- Sub-module imm_gen (combinational, parameter DATA_WIDTH): instruction in, imm and imm_type out.

Test Plan:
- Basic decode:
  - Stimulus: reset, then in_instr=0xFFF10093 (addi x1,x2,-1), pc=0x100, out_ready=1.
  - Required response: next cycle out_valid=1, rd=1, rs1=2, imm=0xFFFFFFFF, imm_type=IMM_I, rd_we=1, rs2_used=0, out_pc=0x100.
- Immediate formats, back-to-back:
  - Stimulus: 0x00112223 (sw), 0xFE000EE3 (beq), 0x12345037 (lui), 0x001000EF (jal x1).
  - Required response: imm 0x4/IMM_S, 0xFFFFFFFC/IMM_B, 0x12345000/IMM_U, 0x800/IMM_J, one per cycle; with DATA_WIDTH=64, beq imm=0xFFFFFFFFFFFFFFFC.
- Backpressure:
  - Stimulus: hold out_ready=0 and send 3 instructions.
  - Required response: two accepted, then in_ready=0; outputs stable on the first.
  - Then release out_ready: bundles drain in order, no loss or duplication.
- Flush:
  - Stimulus: state TWO, then flush=1 with in_valid=1.
  - Required response: next cycle out_valid=0, in_ready=1, dropped instruction never appears.
- Illegal instructions:
  - Stimulus: in_instr=0x00000000, and separately 0x0000007F.
  - Required response: illegal=1, imm=0, rd_we=rs1_used=rs2_used=0, out_valid=1.
- Reset mid-operation:
  - Stimulus: assert arst asynchronously while in state TWO.
  - Required response: out_valid drops immediately without waiting for a clock edge; in_ready=1; after release the first new instruction decodes correctly.
